// File: rtl/riscv_decode_stage.sv
// -----------------------------------------------------------------------------
// riscv_decode_stage
//
// Registered RV32I instruction-decode stage sitting between fetch and execute.
// It extracts the register and function fields, builds the sign-extended
// immediate for every base format, classifies the format and (optionally)
// flags illegal encodings. A single pipeline register with a valid/ready
// handshake gives one-cycle latency, full throughput, back-pressure and flush.
//
// Parameters:
//   XLEN  immediate/datapath width (must be >= 32); immediates sign-extend
//         from instruction bit 31.
//   PC_W  width of the PC sideband carried with the instruction.
//
// Optional feature:
//   DECODE_ILLEGAL_CHECK_EN  when defined, 'illegal' is computed from the
//   opcode map and the OP / OP-IMM funct7 rules; when undefined, 'illegal'
//   is constant 0 (unmapped opcodes still decode as fmt 0, imm 0, no write).
//
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready   fetch-side handshake; in_ready = !out_valid || out_ready
//   instruction, pc_in  raw instruction word and its PC
//   flush               kill the held instruction and drop any incoming one
//   out_valid/out_ready execute-side handshake
//   pc_out, opcode, rd, rs1, rs2, funct3, funct7   registered fields
//   imm, imm_fmt        sign-extended immediate and its format
//                       (0=R/none, 1=I, 2=S, 3=B, 4=U, 5=J)
//   rd_wen, illegal     destination write enable, unrecognised encoding
// -----------------------------------------------------------------------------
module riscv_decode_stage #(
  parameter int XLEN = 32,
  parameter int PC_W = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     instruction,
  input  logic [PC_W-1:0] pc_in,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [PC_W-1:0] pc_out,
  output logic [6:0]      opcode,
  output logic [4:0]      rd,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  output logic [2:0]      funct3,
  output logic [6:0]      funct7,
  output logic [XLEN-1:0] imm,
  output logic [2:0]      imm_fmt,
  output logic            rd_wen,
  output logic            illegal
);

  // Base opcode map.
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  // Immediate format codes as presented on imm_fmt.
  localparam logic [2:0] FMT_NONE = 3'd0;
  localparam logic [2:0] FMT_I    = 3'd1;
  localparam logic [2:0] FMT_S    = 3'd2;
  localparam logic [2:0] FMT_B    = 3'd3;
  localparam logic [2:0] FMT_U    = 3'd4;
  localparam logic [2:0] FMT_J    = 3'd5;

  // ---------------------------------------------------------------------------
  // Immediate builders: each returns the 32-bit sign-extended immediate.
  // ---------------------------------------------------------------------------
  function automatic logic [31:0] imm_i(input logic [31:0] inst);
    return {{21{inst[31]}}, inst[30:20]};
  endfunction

  function automatic logic [31:0] imm_s(input logic [31:0] inst);
    return {{21{inst[31]}}, inst[30:25], inst[11:7]};
  endfunction

  function automatic logic [31:0] imm_b(input logic [31:0] inst);
    return {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
  endfunction

  function automatic logic [31:0] imm_u(input logic [31:0] inst);
    return {inst[31], inst[30:12], 12'b0};
  endfunction

  function automatic logic [31:0] imm_j(input logic [31:0] inst);
    return {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
  endfunction

  // Widen a 32-bit immediate to XLEN; the replication count is never zero
  // because XLEN >= 32.
  function automatic logic [XLEN-1:0] sext_xlen(input logic [31:0] v);
    return {{(XLEN-31){v[31]}}, v[30:0]};
  endfunction

  // Field views of the incoming word.
  logic [6:0]      op_s;
  logic [2:0]      f3_s;
  logic [6:0]      f7_s;
  logic [4:0]      rd_s;

  // Decode results for the incoming word.
  logic [31:0]     imm32_s;
  logic [2:0]      fmt_s;
  logic            writes_s;
  logic            illegal_s;
  logic            rd_wen_s;

  // Handshake.
  logic            in_ready_s;
  logic            capture_s;

  // Pipeline register.
  logic            valid_r;
  logic [PC_W-1:0] pc_r;
  logic [6:0]      opcode_r;
  logic [4:0]      rd_r;
  logic [4:0]      rs1_r;
  logic [4:0]      rs2_r;
  logic [2:0]      funct3_r;
  logic [6:0]      funct7_r;
  logic [XLEN-1:0] imm_r;
  logic [2:0]      fmt_r;
  logic            rd_wen_r;
  logic            illegal_r;

  assign op_s = instruction[6:0];
  assign rd_s = instruction[11:7];
  assign f3_s = instruction[14:12];
  assign f7_s = instruction[31:25];

  // Format classification and immediate selection from the opcode.
  always_comb begin
    imm32_s  = 32'd0;
    fmt_s    = FMT_NONE;
    writes_s = 1'b0;
    case (op_s)
      OPC_LOAD, OPC_OP_IMM, OPC_JALR, OPC_SYSTEM: begin
        imm32_s  = imm_i(instruction);
        fmt_s    = FMT_I;
        writes_s = 1'b1;
      end
      OPC_STORE: begin
        imm32_s  = imm_s(instruction);
        fmt_s    = FMT_S;
        writes_s = 1'b0;
      end
      OPC_BRANCH: begin
        imm32_s  = imm_b(instruction);
        fmt_s    = FMT_B;
        writes_s = 1'b0;
      end
      OPC_LUI, OPC_AUIPC: begin
        imm32_s  = imm_u(instruction);
        fmt_s    = FMT_U;
        writes_s = 1'b1;
      end
      OPC_JAL: begin
        imm32_s  = imm_j(instruction);
        fmt_s    = FMT_J;
        writes_s = 1'b1;
      end
      OPC_OP: begin
        imm32_s  = 32'd0;
        fmt_s    = FMT_NONE;
        writes_s = 1'b1;
      end
      OPC_MISC_MEM: begin
        imm32_s  = 32'd0;
        fmt_s    = FMT_NONE;
        writes_s = 1'b0;
      end
      default: begin
        // Unmapped opcode: no immediate, never writes a register.
        imm32_s  = 32'd0;
        fmt_s    = FMT_NONE;
        writes_s = 1'b0;
      end
    endcase
  end

`ifdef DECODE_ILLEGAL_CHECK_EN
  // Illegal-encoding detection: opcode map, quadrant bits and the funct7
  // values allowed for OP and for the OP-IMM shift instructions.
  always_comb begin
    illegal_s = 1'b0;
    if (instruction[1:0] != 2'b11) begin
      illegal_s = 1'b1;
    end else begin
      case (op_s)
        OPC_OP: begin
          illegal_s = (f7_s != 7'b0000000) && (f7_s != 7'b0100000);
        end
        OPC_OP_IMM: begin
          if (f3_s == 3'b001) begin
            illegal_s = (f7_s != 7'b0000000);
          end else if (f3_s == 3'b101) begin
            illegal_s = (f7_s != 7'b0000000) && (f7_s != 7'b0100000);
          end else begin
            illegal_s = 1'b0;
          end
        end
        OPC_LOAD, OPC_MISC_MEM, OPC_AUIPC, OPC_STORE, OPC_LUI,
        OPC_BRANCH, OPC_JALR, OPC_JAL, OPC_SYSTEM: begin
          illegal_s = 1'b0;
        end
        default: begin
          illegal_s = 1'b1;
        end
      endcase
    end
  end
`else
  assign illegal_s = 1'b0;
`endif

  // x0 is never written, and an illegal encoding must not update state.
  assign rd_wen_s = writes_s && (rd_s != 5'd0) && !illegal_s;

  // Ready depends only on the held entry and the consumer, never on in_valid.
  assign in_ready_s = !valid_r || out_ready;
  assign capture_s  = in_valid && in_ready_s;

  // Occupancy of the pipeline register: flush wins, then capture, then drain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_r <= 1'b0;
    end else if (flush) begin
      valid_r <= 1'b0;
    end else if (capture_s) begin
      valid_r <= 1'b1;
    end else if (out_ready) begin
      valid_r <= 1'b0;
    end else begin
      valid_r <= valid_r;
    end
  end

  // Decoded payload: loaded on an accepted (non-flushed) capture, else held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_r      <= {PC_W{1'b0}};
      opcode_r  <= 7'd0;
      rd_r      <= 5'd0;
      rs1_r     <= 5'd0;
      rs2_r     <= 5'd0;
      funct3_r  <= 3'd0;
      funct7_r  <= 7'd0;
      imm_r     <= {XLEN{1'b0}};
      fmt_r     <= FMT_NONE;
      rd_wen_r  <= 1'b0;
      illegal_r <= 1'b0;
    end else if (capture_s && !flush) begin
      pc_r      <= pc_in;
      opcode_r  <= op_s;
      rd_r      <= rd_s;
      rs1_r     <= instruction[19:15];
      rs2_r     <= instruction[24:20];
      funct3_r  <= f3_s;
      funct7_r  <= f7_s;
      imm_r     <= sext_xlen(imm32_s);
      fmt_r     <= fmt_s;
      rd_wen_r  <= rd_wen_s;
      illegal_r <= illegal_s;
    end else begin
      pc_r      <= pc_r;
      opcode_r  <= opcode_r;
      rd_r      <= rd_r;
      rs1_r     <= rs1_r;
      rs2_r     <= rs2_r;
      funct3_r  <= funct3_r;
      funct7_r  <= funct7_r;
      imm_r     <= imm_r;
      fmt_r     <= fmt_r;
      rd_wen_r  <= rd_wen_r;
      illegal_r <= illegal_r;
    end
  end

  assign in_ready  = in_ready_s;
  assign out_valid = valid_r;
  assign pc_out    = pc_r;
  assign opcode    = opcode_r;
  assign rd        = rd_r;
  assign rs1       = rs1_r;
  assign rs2       = rs2_r;
  assign funct3    = funct3_r;
  assign funct7    = funct7_r;
  assign imm       = imm_r;
  assign imm_fmt   = fmt_r;
  assign rd_wen    = rd_wen_r;
  assign illegal   = illegal_r;

endmodule
